// File: rtl/freq_bcd_conv.sv
// Sequential double-dabble converter: measured frequency -> packed BCD plus significant-digit count.
// Optional build macro FREQ_BCD_BLANK_EN replaces leading zero digits with the 4'hF blank code.
module freq_bcd_conv #(
    parameter int BIN_W  = 32,
    parameter int DIGITS = 10
) (
    input  logic                  clk_base,
    input  logic                  reset,
    input  logic [BIN_W-1:0]      freq_in,
    input  logic                  upd,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic [3:0]            digit_cnt,
    output logic                  valid,
    output logic                  busy
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(BIN_W + 1);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(BIN_W - 1);

`ifdef FREQ_BCD_BLANK_EN
    localparam logic [BCD_W-1:0] BCD_RST = {{(DIGITS-1){4'hF}}, 4'h0};
`else
    localparam logic [BCD_W-1:0] BCD_RST = {BCD_W{1'b0}};
`endif

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    function automatic logic [BCD_W-1:0] dabble_adjust(input logic [BCD_W-1:0] acc);
        logic [BCD_W-1:0] res;
        res = acc;
        for (int d = 0; d < DIGITS; d++) begin
            if (acc[4*d +: 4] >= 4'd5) begin
                res[4*d +: 4] = acc[4*d +: 4] + 4'd3;
            end else begin
                res[4*d +: 4] = acc[4*d +: 4];
            end
        end
        return res;
    endfunction

    function automatic logic [3:0] sig_digits(input logic [BCD_W-1:0] acc);
        logic [3:0] n;
        n = 4'd1;
        for (int d = 1; d < DIGITS; d++) begin
            if (acc[4*d +: 4] != 4'd0) begin
                n = 4'(d + 1);
            end else begin
                n = n;
            end
        end
        return n;
    endfunction

    // Digit 0 is always shown, so blanking starts at index 1.
    function automatic logic [BCD_W-1:0] blank_leading(input logic [BCD_W-1:0] acc,
                                                        input logic [3:0]       n);
        logic [BCD_W-1:0] res;
        res = acc;
        for (int d = 1; d < DIGITS; d++) begin
            if (d >= int'(n)) begin
                res[4*d +: 4] = 4'hF;
            end else begin
                res[4*d +: 4] = acc[4*d +: 4];
            end
        end
        return res;
    endfunction

    state_t               r_state;
    state_t               w_state_nxt;
    logic                 r_upd_d;
    logic                 r_pend;
    logic [BIN_W-1:0]     r_bin_sr;
    logic [BCD_W-1:0]     r_bcd_acc;
    logic [CNT_W-1:0]     r_cnt;
    logic [BCD_W-1:0]     r_bcd_out;
    logic [3:0]           r_digit_cnt;
    logic                 r_valid;
    logic                 r_busy;

    logic                 w_edge;
    logic                 w_load;
    logic                 w_shift;
    logic                 w_done;
    logic [BCD_W-1:0]     w_adj;
    logic [3:0]           w_sig;
    logic [BCD_W-1:0]     w_result;

    assign w_edge   = upd & ~r_upd_d;
    assign w_adj    = dabble_adjust(r_bcd_acc);
    assign w_sig    = sig_digits(r_bcd_acc);
`ifdef FREQ_BCD_BLANK_EN
    assign w_result = blank_leading(r_bcd_acc, w_sig);
`else
    assign w_result = r_bcd_acc;
`endif

    // State register.
    always_ff @(posedge clk_base) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and per-cycle control decode.
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_shift     = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_edge || r_pend) begin
                    w_load      = 1'b1;
                    w_state_nxt = S_SHIFT;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_SHIFT: begin
                w_shift = 1'b1;
                if (r_cnt == LAST_ITER) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_state_nxt = S_SHIFT;
                end
            end
            S_DONE: begin
                w_done      = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Conversion datapath, request latch and registered outputs.
    always_ff @(posedge clk_base) begin
        if (reset) begin
            r_upd_d     <= 1'b0;
            r_pend      <= 1'b0;
            r_bin_sr    <= {BIN_W{1'b0}};
            r_bcd_acc   <= {BCD_W{1'b0}};
            r_cnt       <= {CNT_W{1'b0}};
            r_bcd_out   <= BCD_RST;
            r_digit_cnt <= 4'd1;
            r_valid     <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_upd_d <= upd;
            r_valid <= w_done;
            // A request arriving mid-conversion is held one-deep and replayed from IDLE.
            if (w_load) begin
                r_pend <= 1'b0;
            end else if (w_edge) begin
                r_pend <= 1'b1;
            end else begin
                r_pend <= r_pend;
            end
            if (w_load) begin
                r_bin_sr  <= freq_in;
                r_bcd_acc <= {BCD_W{1'b0}};
                r_cnt     <= {CNT_W{1'b0}};
                r_busy    <= 1'b1;
            end else if (w_shift) begin
                {r_bcd_acc, r_bin_sr} <= {w_adj, r_bin_sr} << 1;
                r_cnt  <= r_cnt + CNT_W'(1);
                r_busy <= 1'b1;
            end else if (w_done) begin
                r_bcd_out   <= w_result;
                r_digit_cnt <= w_sig;
                r_busy      <= 1'b1;
            end else begin
                r_busy <= 1'b0;
            end
        end
    end

    assign bcd_out   = r_bcd_out;
    assign digit_cnt = r_digit_cnt;
    assign valid     = r_valid;
    assign busy      = r_busy;

endmodule

// File: tb/tb_freq_bcd_conv.sv
// Self-checking bench for freq_bcd_conv: directed corners plus random values against a decimal model.
module tb_freq_bcd_conv;

    logic        clk_base = 1'b0;
    logic        reset;
    logic [31:0] freq_in;
    logic        upd;
    logic [39:0] bcd_out;
    logic [3:0]  digit_cnt;
    logic        valid;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    logic [39:0] last_bcd;
    logic [3:0]  last_dc;

`ifdef FREQ_BCD_BLANK_EN
    localparam logic [39:0] RST_EXP = 40'hFFFFFFFFF0;
`else
    localparam logic [39:0] RST_EXP = 40'h0;
`endif

    freq_bcd_conv #(.BIN_W(32), .DIGITS(10)) dut (
        .clk_base  (clk_base),
        .reset     (reset),
        .freq_in   (freq_in),
        .upd       (upd),
        .bcd_out   (bcd_out),
        .digit_cnt (digit_cnt),
        .valid     (valid),
        .busy      (busy)
    );

    always #5 clk_base = ~clk_base;

    function automatic logic [3:0] model_dc(input logic [31:0] val);
        int unsigned t;
        int          n;
        t = val / 10;
        n = 1;
        while (t != 0) begin
            n++;
            t = t / 10;
        end
        return 4'(n);
    endfunction

    function automatic logic [39:0] model_bcd(input logic [31:0] val);
        logic [39:0] res;
        int unsigned v;
        int          n;
        v   = val;
        n   = int'(model_dc(val));
        res = 40'h0;
        for (int i = 0; i < 10; i++) begin
            res[4*i +: 4] = 4'(v % 10);
            v = v / 10;
`ifdef FREQ_BCD_BLANK_EN
            if (i >= n) res[4*i +: 4] = 4'hF;
`endif
        end
        return res;
    endfunction

    task automatic step();
        @(posedge clk_base);
        #1;
    endtask

    task automatic test_reset();
        reset   = 1'b1;
        upd     = 1'b0;
        freq_in = 32'd0;
        step();
        step();
        reset = 1'b0;
        checks++; if (bcd_out !== RST_EXP) begin failures++; $display("FAIL reset_bcd: got %h want %h", bcd_out, RST_EXP); end
        checks++; if (digit_cnt !== 4'd1) begin failures++; $display("FAIL reset_dc: got %0d want 1", digit_cnt); end
        checks++; if (valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b want 0", valid); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", busy); end
        last_bcd = RST_EXP;
        last_dc  = 4'd1;
        step();
    endtask

    task automatic run_one(input logic [31:0] val, input string name);
        logic [39:0] exp_bcd, got_bcd;
        logic [3:0]  exp_dc, got_dc;
        int          lat, busy_n, pulses;
        bit          stable_ok;
        exp_bcd = model_bcd(val);
        exp_dc  = model_dc(val);
        got_bcd = 40'hx;
        got_dc  = 4'hx;
        lat = -1; busy_n = 0; pulses = 0; stable_ok = 1'b1;
        freq_in = val;
        upd     = 1'b1;
        for (int c = 1; c <= 60; c++) begin
            step();
            if (c == 3) upd = 1'b0;
            if (busy === 1'b1) busy_n++;
            if (valid === 1'b1) begin
                pulses++;
                if (lat < 0) begin
                    lat     = c;
                    got_bcd = bcd_out;
                    got_dc  = digit_cnt;
                end
            end else if (c < 34 && (bcd_out !== last_bcd || digit_cnt !== last_dc)) begin
                stable_ok = 1'b0;
            end
        end
        checks++; if (lat != 34) begin failures++; $display("FAIL %s_latency: got %0d want 34", name, lat); end
        checks++; if (pulses != 1) begin failures++; $display("FAIL %s_pulses: got %0d want 1", name, pulses); end
        checks++; if (busy_n != 34) begin failures++; $display("FAIL %s_busy_cycles: got %0d want 34", name, busy_n); end
        checks++; if (got_bcd !== exp_bcd) begin failures++; $display("FAIL %s_bcd: got %h want %h", name, got_bcd, exp_bcd); end
        checks++; if (got_dc !== exp_dc) begin failures++; $display("FAIL %s_dc: got %0d want %0d", name, got_dc, exp_dc); end
        checks++; if (!stable_ok) begin failures++; $display("FAIL %s_early_change: got changed want stable", name); end
        last_bcd = exp_bcd;
        last_dc  = exp_dc;
    endtask

    task automatic test_directed();
        run_one(32'd0,          "zero");
        run_one(32'hFFFF_FFFF,  "max");
        run_one(32'd12345,      "v12345");
        run_one(32'd9,          "v9");
        run_one(32'd10,         "v10");
        run_one(32'd1000000000, "v1e9");
    endtask

    task automatic test_random();
        logic [31:0] v;
        for (int i = 0; i < 8; i++) begin
            v = $urandom >> $urandom_range(0, 31);
            run_one(v, "random");
        end
    endtask

    task automatic test_upd_held();
        int          pulses;
        logic [39:0] got_bcd;
        logic [3:0]  got_dc;
        pulses  = 0;
        got_bcd = 40'hx;
        got_dc  = 4'hx;
        freq_in = 32'd999;
        upd     = 1'b1;
        for (int c = 1; c <= 140; c++) begin
            step();
            if (c == 100) upd = 1'b0;
            if (valid === 1'b1) begin
                pulses++;
                got_bcd = bcd_out;
                got_dc  = digit_cnt;
            end
        end
        checks++; if (pulses != 1) begin failures++; $display("FAIL held_pulses: got %0d want 1", pulses); end
        checks++; if (got_bcd !== model_bcd(32'd999)) begin failures++; $display("FAIL held_bcd: got %h want %h", got_bcd, model_bcd(32'd999)); end
        checks++; if (got_dc !== 4'd3) begin failures++; $display("FAIL held_dc: got %0d want 3", got_dc); end
        last_bcd = model_bcd(32'd999);
        last_dc  = 4'd3;
    endtask

    task automatic test_back_to_back();
        logic [39:0] seen_bcd[$];
        int          seen_at[$];
        int          busy_n;
        seen_bcd.delete();
        seen_at.delete();
        busy_n  = 0;
        freq_in = 32'd100;
        upd     = 1'b1;
        for (int c = 1; c <= 110; c++) begin
            step();
            if (c == 2) upd = 1'b0;
            if (c == 10) begin
                freq_in = 32'd250;
                upd     = 1'b1;
            end
            if (busy === 1'b1) busy_n++;
            if (valid === 1'b1) begin
                seen_bcd.push_back(bcd_out);
                seen_at.push_back(c);
            end
        end
        upd = 1'b0;
        checks++; if (seen_bcd.size() != 2) begin failures++; $display("FAIL b2b_pulses: got %0d want 2", seen_bcd.size()); end
        if (seen_bcd.size() == 2) begin
            checks++; if (seen_bcd[0] !== model_bcd(32'd100)) begin failures++; $display("FAIL b2b_first: got %h want %h", seen_bcd[0], model_bcd(32'd100)); end
            checks++; if (seen_bcd[1] !== model_bcd(32'd250)) begin failures++; $display("FAIL b2b_second: got %h want %h", seen_bcd[1], model_bcd(32'd250)); end
            checks++; if (seen_at[1] - seen_at[0] != 34) begin failures++; $display("FAIL b2b_gap: got %0d want 34", seen_at[1] - seen_at[0]); end
        end
        checks++; if (busy_n != 68) begin failures++; $display("FAIL b2b_busy_cycles: got %0d want 68", busy_n); end
        last_bcd = model_bcd(32'd250);
        last_dc  = model_dc(32'd250);
        step();
    endtask

    task automatic test_reset_mid();
        int pulses, busy_n;
        freq_in = 32'd12345;
        upd     = 1'b1;
        for (int c = 1; c <= 21; c++) begin
            step();
            if (c == 3) upd = 1'b0;
        end
        reset = 1'b1;
        upd   = 1'b1;
        step();
        reset = 1'b0;
        upd   = 1'b0;
        checks++; if (bcd_out !== RST_EXP) begin failures++; $display("FAIL midrst_bcd: got %h want %h", bcd_out, RST_EXP); end
        checks++; if (digit_cnt !== 4'd1) begin failures++; $display("FAIL midrst_dc: got %0d want 1", digit_cnt); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL midrst_busy: got %b want 0", busy); end
        checks++; if (valid !== 1'b0) begin failures++; $display("FAIL midrst_valid: got %b want 0", valid); end
        pulses = 0;
        busy_n = 0;
        for (int c = 1; c <= 50; c++) begin
            step();
            if (valid === 1'b1) pulses++;
            if (busy === 1'b1) busy_n++;
        end
        checks++; if (pulses != 0) begin failures++; $display("FAIL midrst_no_valid: got %0d want 0", pulses); end
        checks++; if (busy_n != 0) begin failures++; $display("FAIL midrst_no_busy: got %0d want 0", busy_n); end
        last_bcd = RST_EXP;
        last_dc  = 4'd1;
        run_one(32'd12345, "after_reset");
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_upd_held();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
